// File: rtl/bus_wrr_arbiter.sv
// Weighted round-robin arbiter: one-cycle one-hot grant, then holds until the
// granted transfer signals i_done. Per-requester credits allow weighted bursts.
module bus_wrr_arbiter #(
    parameter int N            = 2,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N-1:0]              i_request,
    input  logic [N*WEIGHT_WIDTH-1:0] i_weight,
    input  logic                      i_done,
    output logic [N-1:0]              o_grant,
    output logic                      o_busy
);

    localparam int PW = $clog2(N);
    localparam logic [WEIGHT_WIDTH-1:0] CREDIT_ONE = WEIGHT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BUSY
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [N-1:0]            grant_q, grant_d;
    logic [WEIGHT_WIDTH-1:0] credit_q   [N];
    logic [WEIGHT_WIDTH-1:0] credit_d   [N];
    logic [WEIGHT_WIDTH-1:0] weight_i   [N];
    logic [WEIGHT_WIDTH-1:0] eff_credit [N];
    logic [N-1:0]            eligible;
    logic                    reload;
    logic                    found;
    int unsigned             sel;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = '0;
        credit_d = credit_q;
        eligible = '0;
        found    = 1'b0;
        sel      = 0;

        for (int unsigned i = 0; i < N; i++) begin
            weight_i[i] = i_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            eligible[i] = i_request[i] && (credit_q[i] != '0);
        end

        // Reload when no requester can be served from its remaining credit.
        reload = (eligible == '0) && (|i_request);

        for (int unsigned i = 0; i < N; i++) begin
            if (reload) begin
                eff_credit[i] = (weight_i[i] == '0) ? CREDIT_ONE : weight_i[i];
            end else begin
                eff_credit[i] = credit_q[i];
            end
        end

        for (int unsigned off = 0; off < N; off++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && (i == (32'(ptr_q) + off) % N) &&
                    i_request[i] && (eff_credit[i] != '0)) begin
                    found = 1'b1;
                    sel   = i;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    for (int unsigned i = 0; i < N; i++) begin
                        if (reload) begin
                            credit_d[i] = eff_credit[i];
                        end
                        if (i == sel) begin
                            credit_d[i] = eff_credit[i] - CREDIT_ONE;
                            grant_d[i]  = 1'b1;
                            ptr_d       = (credit_d[i] == '0) ? PW'((i + 1) % N) : PW'(i);
                        end
                    end
                end
            end
            GRANT:   state_d = BUSY;
            BUSY:    if (i_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            credit_q <= credit_d;
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_bus_wrr_arbiter.sv
// Self-checking bench for bus_wrr_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against a transaction-level reference model.
module tb_bus_wrr_arbiter;

    localparam int N  = 2;
    localparam int WW = 4;

    logic              clk    = 1'b0;
    logic              rst    = 1'b0;
    logic [N-1:0]      req    = '0;
    logic [N*WW-1:0]   weight = '0;
    logic              done   = 1'b0;
    logic [N-1:0]      grant;
    logic              busy;

    always #5 clk = ~clk;

    bus_wrr_arbiter #(
        .N            (N),
        .WEIGHT_WIDTH (WW)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_request (req),
        .i_weight  (weight),
        .i_done    (done),
        .o_grant   (grant),
        .o_busy    (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 = idle, 1 = grant cycle, 2 = waiting for done.
    int           m_phase = 0;
    int           m_credit [N];
    int           m_prio = 0;
    logic [N-1:0] m_grant = '0;
    int           dut_log [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int weight_of(input int i);
        int v;
        v = int'((weight >> (i * WW)) & ((1 << WW) - 1));
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_tick();
        bit any;
        int win;
        if (rst) begin
            m_phase = 0;
            m_prio  = 0;
            m_grant = '0;
            foreach (m_credit[i]) m_credit[i] = 0;
            return;
        end
        m_grant = '0;
        if (m_phase == 0) begin
            if (req != '0) begin
                any = 0;
                for (int i = 0; i < N; i++) if (req[i] && m_credit[i] > 0) any = 1;
                if (!any) for (int i = 0; i < N; i++) m_credit[i] = weight_of(i);
                win = -1;
                for (int off = 0; off < N; off++) begin
                    int k;
                    k = (m_prio + off) % N;
                    if (win < 0 && req[k] && m_credit[k] > 0) win = k;
                end
                m_credit[win] -= 1;
                m_prio  = (m_credit[win] == 0) ? (win + 1) % N : win;
                m_grant = N'(1 << win);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (done) begin
            m_phase = 0;
        end
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        check_eq("grant", 32'(grant), 32'(m_grant));
        check_eq("busy", 32'(busy), 32'(m_phase != 0));
        check_eq("onehot", 32'($onehot0(grant)), 32'd1);
        for (int i = 0; i < N; i++) if (grant[i]) dut_log.push_back(i);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        step();
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        dut_log.delete();
    endtask

    // Steps with done returned in the first BUSY cycle until n grants are logged.
    task automatic run_grants(input int n, input int budget);
        int c;
        c = 0;
        while (dut_log.size() < n && c < budget) begin
            step();
            done = (m_phase == 2);
            c++;
        end
        done = 1'b0;
        check_eq("grant_count", 32'(dut_log.size()), 32'(n));
    endtask

    initial begin
        int exp_w  [6] = '{0, 0, 1, 0, 0, 1};
        int exp_z  [4] = '{0, 1, 0, 1};
        int exp_s  [7] = '{0, 0, 0, 1, 1, 1, 0};

        do_reset();
        for (int c = 0; c < 20; c++) begin
            step();
            check_eq("idle_grant", 32'(grant), 32'd0);
            check_eq("idle_busy", 32'(busy), 32'd0);
        end

        // Latency: request sampled at t, grant at t+1 only, done at t+4.
        weight = {4'd1, 4'd1};
        req    = 2'b10;
        step();
        check_eq("lat_grant", 32'(grant), 32'h2);
        check_eq("lat_busy_g", 32'(busy), 32'd1);
        req = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("lat_grant_off", 32'(grant), 32'd0);
            check_eq("lat_busy", 32'(busy), 32'd1);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        check_eq("lat_idle", 32'(busy), 32'd0);

        do_reset();
        weight = {4'd1, 4'd2};
        req    = 2'b11;
        run_grants(6, 100);
        for (int i = 0; i < 6; i++) check_eq($sformatf("wseq%0d", i), 32'(dut_log[i]), 32'(exp_w[i]));

        do_reset();
        weight = '0;
        req    = 2'b11;
        run_grants(4, 100);
        for (int i = 0; i < 4; i++) check_eq($sformatf("zseq%0d", i), 32'(dut_log[i]), 32'(exp_z[i]));

        do_reset();
        weight = {4'd3, 4'd3};
        req    = 2'b01;
        run_grants(2, 50);
        req = 2'b11;
        run_grants(7, 100);
        for (int i = 0; i < 7; i++) check_eq($sformatf("sseq%0d", i), 32'(dut_log[i]), 32'(exp_s[i]));

        // Reset during BUSY must discard credits and pointer state.
        do_reset();
        weight = {4'd1, 4'd1};
        req    = 2'b11;
        run_grants(1, 20);
        step();
        check_eq("mid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_grant", 32'(grant), 32'd0);
        dut_log.delete();
        run_grants(1, 20);
        check_eq("mid_first", 32'(dut_log[0]), 32'd0);

        do_reset();
        weight = N*WW'($urandom);
        for (int c = 0; c < 3000; c++) begin
            req  = N'($urandom);
            done = 1'($urandom_range(0, 1));
            rst  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 49) == 0) weight = (N*WW)'($urandom);
            step();
        end
        rst  = 1'b0;
        req  = '0;
        done = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
